// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code encoding, legality check and the
// sequencer state type used by ALU-sharing arbiters.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_PASSB = 4'd4,
    ALU_BNE   = 4'd5,
    ALU_BEQ   = 4'd7
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic alu_ctrl_legal(input logic [3:0] code);
    case (code)
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_AND,
      ALU_PASSB, ALU_BNE, ALU_BEQ: alu_ctrl_legal = 1'b1;
      default:                     alu_ctrl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any_valid
);

  always_comb begin
    logic [IDW-1:0] k;
    k         = '0;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = IDW'((int'(ptr) + i) % NREQ);
      if (!any_valid && req[k]) begin
        any_valid = 1'b1;
        idx       = k;
        grant[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters: round-robin
// accept, one execute cycle, then a tagged response held until consumed.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_srca,
  input  logic [NREQ*WIDTH-1:0] req_srcb,
  input  logic [NREQ*4-1:0]     req_ctrl,
  output logic [WIDTH-1:0]      alu_srca,
  output logic [WIDTH-1:0]      alu_srcb,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_zero,
  output logic                  resp_err
);

  arb_state_t       state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   pick_idx;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_srca, sel_srcb;
  logic [3:0]       sel_ctrl;
  logic [WIDTH-1:0] srca_p0, srcb_p0;
  logic [3:0]       ctrl_p0;
  logic [IDW-1:0]   id_p0;
  logic             legal_p0;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  assign accept   = (state == IDLE) && any_valid;
  assign legal_p0 = alu_ctrl_legal(ctrl_p0);

  always_comb begin
    sel_srca = '0;
    sel_srcb = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_srca = req_srca[i*WIDTH +: WIDTH];
        sel_srcb = req_srcb[i*WIDTH +: WIDTH];
        sel_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) ? grant : '0;
    resp_valid = (state == RESP);
  end

  // Stage p0: operand registers, loaded only on an accept in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      srca_p0 <= '0;
      srcb_p0 <= '0;
      ctrl_p0 <= '0;
      id_p0   <= '0;
    end else if (accept) begin
      rr_ptr  <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      srca_p0 <= sel_srca;
      srcb_p0 <= sel_srcb;
      ctrl_p0 <= sel_ctrl;
      id_p0   <= pick_idx;
    end
  end

  assign alu_srca = srca_p0;
  assign alu_srcb = srcb_p0;
  assign alu_ctrl = ctrl_p0;

  // Stage p1: response capture at the end of EXEC; illegal codes mask the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id   <= '0;
      resp_data <= '0;
      resp_zero <= 1'b0;
      resp_err  <= 1'b0;
    end else if (state == EXEC) begin
      resp_id   <= id_p0;
      resp_data <= legal_p0 ? alu_result : '0;
      resp_zero <= legal_p0 & alu_zero;
      resp_err  <= ~legal_p0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter with a behavioural ALU
// and a round-robin reference model.
module tb_alu_share_arbiter;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_srca;
  logic [N*W-1:0]   req_srcb;
  logic [N*4-1:0]   req_ctrl;
  logic [W-1:0]     alu_srca, alu_srcb, alu_result;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;
  logic             resp_valid, resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [W-1:0]     resp_data;
  logic             resp_zero, resp_err;

  alu_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_ctrl(req_ctrl),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_err(resp_err)
  );

  typedef struct {
    int         id;
    logic [W-1:0] data;
    logic       zero;
    logic       err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0] c;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mptr = 0;
  int   racc = 0;
  int   ready_mode = 1;
  bit   rr_refill = 0;
  bit   rand_mode = 0;
  bit   v[N];
  bit   acc_pend[N];
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];
  logic [3:0]   pc[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: {zero, result}; illegal codes return junk the DUT must drop
  function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] c);
    logic [W-1:0] r;
    r = '0;
    case (c)
      4'd0:       r = a + b;
      4'd1:       r = a - b;
      4'd2:       r = a ^ b;
      4'd3:       r = a & b;
      4'd4:       r = b;
      4'd5, 4'd7: r = a - b;
      default:    return {1'b1, 32'hDEAD_BEEF};
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {alu_zero, alu_result} = ref_alu(alu_srca, alu_srcb, alu_ctrl);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_exp(input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] c);
    v[i] = 1'b1; pa[i] = a; pb[i] = b; pc[i] = c;
  endtask

  task automatic rand_req(input int i);
    logic [W-1:0] a, b;
    logic [3:0]   c;
    int           legal_codes[7] = '{0, 1, 2, 3, 4, 5, 7};
    a = $urandom;
    b = ($urandom % 4 == 0) ? a : $urandom;
    c = ($urandom % 5 == 0) ? 4'($urandom_range(0, 15)) : 4'(legal_codes[$urandom_range(0, 6)]);
    set_req(i, a, b, c);
  endtask

  // One cycle of stimulus plus the request-side checks of the model
  task automatic step();
    logic [N-1:0] vv;
    int           e, gi;
    exp_t         x;
    logic [W:0]   r;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_pend[i]) begin v[i] = 1'b0; acc_pend[i] = 1'b0; end
      if (rr_refill && racc < 5 && !v[i]) set_req(i, W'(10 * i), W'(4 * i), 4'd1);
      if (rand_mode) begin
        if (!v[i] && $urandom % 3 == 0) rand_req(i);
        else if (v[i] && $urandom % 25 == 0) v[i] = 1'b0;
      end
    end
    case (ready_mode)
      0:       resp_ready = 1'b0;
      1:       resp_ready = 1'b1;
      default: resp_ready = ($urandom % 3 != 0);
    endcase
    for (int i = 0; i < N; i++) begin
      vv[i] = v[i];
      req_srca[i*W +: W] = pa[i];
      req_srcb[i*W +: W] = pb[i];
      req_ctrl[i*4 +: 4] = pc[i];
    end
    req_valid = vv;
    #1;
    if (sb.size() > 0) begin
      chk("ready_while_busy", 64'(req_ready), 64'd0);
      chk("alu_srca_hold", 64'(alu_srca), 64'(sb[0].a));
      chk("alu_srcb_hold", 64'(alu_srcb), 64'(sb[0].b));
      chk("alu_ctrl_hold", 64'(alu_ctrl), 64'(sb[0].c));
    end else if (vv != '0) begin
      e = rr_exp(mptr);
      chk("grant_onehot", 64'(req_ready), 64'(1) << e);
      gi = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
      glog.push_back(gi);
      r = ref_alu(pa[e], pb[e], pc[e]);
      x.id = e; x.a = pa[e]; x.b = pb[e]; x.c = pc[e]; x.acc_cyc = cyc;
      if (pc[e] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7}) begin
        x.data = r[W-1:0]; x.zero = r[W]; x.err = 1'b0;
      end else begin
        x.data = '0; x.zero = 1'b0; x.err = 1'b1;
      end
      sb.push_back(x);
      acc_pend[e] = 1'b1;
      mptr = (e + 1) % N;
      racc++;
    end else begin
      chk("ready_no_req", 64'(req_ready), 64'd0);
    end
  endtask

  task automatic drain(input int limit);
    bit busy;
    for (int t = 0; t < limit; t++) begin
      busy = (sb.size() > 0);
      for (int i = 0; i < N; i++) if (v[i]) busy = 1'b1;
      if (!busy) return;
      step();
    end
    chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // Response monitor: pops the scoreboard on each response handshake
  initial begin
    bit           seen, held;
    logic [IDW-1:0] h_id;
    logic [W-1:0] h_data;
    logic         h_zero, h_err;
    exp_t         e;
    seen = 0; held = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin seen = 0; held = 0; continue; end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = sb[0];
          if (!seen) begin
            chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
            seen = 1;
          end
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_zero", 64'(resp_zero), 64'(e.zero));
          chk("resp_err", 64'(resp_err), 64'(e.err));
          if (held) begin
            chk("stable_id", 64'(resp_id), 64'(h_id));
            chk("stable_data", 64'(resp_data), 64'(h_data));
            chk("stable_flags", {62'd0, resp_zero, resp_err}, {62'd0, h_zero, h_err});
          end
          if (resp_ready) begin
            void'(sb.pop_front());
            seen = 0; held = 0;
          end else begin
            held = 1; h_id = resp_id; h_data = resp_data; h_zero = resp_zero; h_err = resp_err;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_order[5] = '{0, 1, 2, 3, 0};
    bit got;
    rst_n = 1'b0; req_valid = '0; req_srca = '0; req_srcb = '0; req_ctrl = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin v[i] = 0; acc_pend[i] = 0; pa[i] = '0; pb[i] = '0; pc[i] = '0; end
    #12;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_alu_srca", 64'(alu_srca), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_id_err", {61'd0, resp_id, resp_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters continuously valid with subtract
    glog.delete(); racc = 0; rr_refill = 1;
    for (int t = 0; t < 60 && racc < 5; t++) step();
    rr_refill = 0;
    drain(100);
    for (int k = 0; k < 5; k++)
      chk("rr_order", 64'(glog.size() > k ? glog[k] : -1), 64'(rr_order[k]));

    // Single add
    set_req(0, 32'd5, 32'd3, 4'd0);
    drain(20);

    // Backpressure in RESP with another requester waiting
    set_req(2, 32'd100, 32'd1, 4'd2);
    set_req(1, 32'd9, 32'd9, 4'd3);
    ready_mode = 0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin step(); got = resp_valid; end
    chk("bp_reach_resp", 64'(got), 64'd1);
    repeat (5) step();
    ready_mode = 1;
    drain(30);

    // Illegal code and compare codes
    set_req(2, 32'h1234, 32'h1234, 4'd6);
    drain(20);
    set_req(1, 32'd7, 32'd7, 4'd5);
    drain(20);
    set_req(3, 32'd1, 32'd2, 4'd7);
    drain(20);

    // Randomized traffic with random backpressure
    rand_mode = 1; ready_mode = 2;
    repeat (400) step();
    rand_mode = 0; ready_mode = 1;
    drain(200);

    // Reset while in EXEC discards the operation and the round-robin pointer
    set_req(2, 32'd11, 32'd22, 4'd0);
    step();
    step();
    rst_n = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin v[i] = 0; acc_pend[i] = 0; end
    sb.delete();
    mptr = 0;
    #1;
    chk("rstx_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstx_alu_srca", 64'(alu_srca), 64'd0);
    chk("rstx_alu_srcb", 64'(alu_srcb), 64'd0);
    chk("rstx_resp_data", 64'(resp_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
    set_req(1, 32'd50, 32'd8, 4'd1);
    set_req(3, 32'd6, 32'd6, 4'd7);
    drain(40);
    chk("post_rst_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd1);
    chk("post_rst_second", 64'(glog.size() > 1 ? glog[1] : -1), 64'd3);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
